// File: rtl/dump_pkg.sv
// Shared definitions for the debug-dump collector: FSM state codes and the
// base addresses of the PC / register / memory sections of the image.
package dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PC   = 3'd1,
        ST_REGS = 3'd2,
        ST_MEM  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int PC_ADDR  = 0;
    localparam int REG_BASE = 1;

    // Memory section starts right after the PC word and the register block.
    function automatic int mem_base(input int num_regs);
        return 1 + num_regs;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles BYTE_WIDTH strobes into DATA_WIDTH words. word_o already includes
// the byte presented this cycle, so the word can be stored on the same edge
// that samples the final strobe.
module byte_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  byte_vld_i,
    input  logic [BYTE_WIDTH-1:0] byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_vld_o
);
    localparam int BPW = DATA_WIDTH / BYTE_WIDTH;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  last;

    assign last = (cnt_q == CW'(BPW - 1));

    // Merge the incoming byte into the partial word (slot write or shift-in).
    always_comb begin
        acc_d = acc_q;
        if (MSB_FIRST != 0) begin
            acc_d = (acc_q << BYTE_WIDTH) | DATA_WIDTH'(byte_i);
        end else begin
            for (int k = 0; k < BPW; k++) begin
                if (cnt_q == CW'(k)) acc_d[k*BYTE_WIDTH +: BYTE_WIDTH] = byte_i;
            end
        end
    end

    // Byte position: cleared by resync, wraps after the last byte of a word.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)           cnt_d = '0;
        else if (byte_vld_i) cnt_d = last ? '0 : cnt_q + 1'b1;
    end

    // Stale slots need no clearing: every slot is rewritten before word_vld_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (byte_vld_i && !clr_i) acc_q <= acc_d;
        end
    end

    assign word_o     = acc_d;
    assign word_vld_o = byte_vld_i && !clr_i && last;

endmodule

// File: rtl/uart_dump_collector.sv
// Receive-side collector for the debug dump stream: packs UART bytes into
// words, files them into a PC / register / memory image, and exposes the
// image through a registered read port. Adds arm, idle timeout and done pulse.
module uart_dump_collector
    import dump_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int NUM_REGS       = 32,
    parameter int MEM_WORDS      = 32,
    parameter int MSB_FIRST      = 0,
    parameter int TIMEOUT_CYCLES = 200000,
    localparam int TOTAL = 1 + NUM_REGS + MEM_WORDS,
    localparam int AW    = $clog2(TOTAL + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_arm,
    input  logic                  i_rx_done,
    input  logic [BYTE_WIDTH-1:0] i_rx_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [2:0]            o_state,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [AW-1:0]         o_word_count
);
    localparam int IW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [AW-1:0] MEM_BASE_A = AW'(mem_base(NUM_REGS));
    localparam logic [AW-1:0] TOTAL_A    = AW'(TOTAL);

    state_e                state_q;
    logic [AW-1:0]         wc_q, wc_d;
    logic [TW-1:0]         idle_q;
    logic [DATA_WIDTH-1:0] pc_q, rd_q;
    logic                  done_q, to_q;
    logic                  busy, byte_ok, to_fire;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_vld;
    logic [DATA_WIDTH-1:0] image_q [TOTAL];

    assign busy    = (state_q == ST_PC) || (state_q == ST_REGS) || (state_q == ST_MEM);
    // Arm beats a coincident strobe; strobes outside a capture are dropped.
    assign byte_ok = busy && i_rx_done && !i_arm;
    assign to_fire = (TIMEOUT_CYCLES != 0) && busy && !i_rx_done && !i_arm &&
                     (idle_q == TW'(TIMEOUT_CYCLES - 1));
    assign wc_d    = wc_q + 1'b1;

    byte_word_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_packer (
        .clk_i      (i_clock),
        .rst_ni     (i_reset),
        .clr_i      (i_arm | to_fire),
        .byte_vld_i (byte_ok),
        .byte_i     (i_rx_data),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    // Capture FSM with word counter, idle timer and the PC/done/timeout flags.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            wc_q    <= '0;
            idle_q  <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_arm) begin
                state_q <= ST_PC;
                wc_q    <= '0;
                idle_q  <= '0;
                to_q    <= 1'b0;
            end else if (to_fire) begin
                state_q <= ST_IDLE;
                idle_q  <= '0;
                to_q    <= 1'b1;
            end else if (busy) begin
                idle_q <= i_rx_done ? '0 : idle_q + 1'b1;
                if (word_vld) begin
                    wc_q <= wc_d;
                    if (wc_q == AW'(PC_ADDR)) pc_q <= word;
                    // Section follows from how many words are now stored.
                    if (wc_d == TOTAL_A) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (wc_d >= MEM_BASE_A) begin
                        state_q <= ST_MEM;
                    end else begin
                        state_q <= ST_REGS;
                    end
                end
            end
        end
    end

    // Image storage; left unreset so it maps onto plain RAM.
    always_ff @(posedge i_clock) begin
        if (word_vld) image_q[wc_q[IW-1:0]] <= word;
    end

    // Registered read; a same-cycle write is seen on the following read.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)                 rd_q <= '0;
        else if (i_rd_addr < TOTAL_A) rd_q <= image_q[i_rd_addr[IW-1:0]];
        else                          rd_q <= '0;
    end

    assign o_rd_data    = rd_q;
    assign o_pc         = pc_q;
    assign o_state      = state_q;
    assign o_busy       = busy;
    assign o_done       = done_q;
    assign o_timeout    = to_q;
    assign o_word_count = wc_q;

endmodule

// File: tb/tb_uart_dump_collector.sv
// Bench for uart_dump_collector: three configurations (32-bit LSB-first with a
// short timeout, 16-bit MSB-first, registers only), random payloads compared
// against word lists expanded to bytes with plain arithmetic.
module tb_uart_dump_collector;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  // Config A: 32/8/32/32, LSB first, timeout 100
  logic a_arm, a_rxd; logic [7:0] a_dat; logic [6:0] a_addr;
  logic [31:0] a_rd, a_pc; logic [2:0] a_st; logic a_busy, a_done, a_to; logic [6:0] a_wc;
  uart_dump_collector #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .NUM_REGS(32), .MEM_WORDS(32),
    .MSB_FIRST(0), .TIMEOUT_CYCLES(100)) u_a (
    .i_clock(clk), .i_reset(rst_n), .i_arm(a_arm), .i_rx_done(a_rxd), .i_rx_data(a_dat),
    .i_rd_addr(a_addr), .o_rd_data(a_rd), .o_pc(a_pc), .o_state(a_st), .o_busy(a_busy),
    .o_done(a_done), .o_timeout(a_to), .o_word_count(a_wc));

  // Config B: 16/8/1/0, MSB first, timeout disabled
  logic b_arm, b_rxd; logic [7:0] b_dat; logic [1:0] b_addr;
  logic [15:0] b_rd, b_pc; logic [2:0] b_st; logic b_busy, b_done, b_to; logic [1:0] b_wc;
  uart_dump_collector #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .NUM_REGS(1), .MEM_WORDS(0),
    .MSB_FIRST(1), .TIMEOUT_CYCLES(0)) u_b (
    .i_clock(clk), .i_reset(rst_n), .i_arm(b_arm), .i_rx_done(b_rxd), .i_rx_data(b_dat),
    .i_rd_addr(b_addr), .o_rd_data(b_rd), .o_pc(b_pc), .o_state(b_st), .o_busy(b_busy),
    .o_done(b_done), .o_timeout(b_to), .o_word_count(b_wc));

  // Config C: 32/8/32/0, LSB first
  logic c_arm, c_rxd; logic [7:0] c_dat; logic [5:0] c_addr;
  logic [31:0] c_rd, c_pc; logic [2:0] c_st; logic c_busy, c_done, c_to; logic [5:0] c_wc;
  uart_dump_collector #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .NUM_REGS(32), .MEM_WORDS(0),
    .MSB_FIRST(0), .TIMEOUT_CYCLES(100000)) u_c (
    .i_clock(clk), .i_reset(rst_n), .i_arm(c_arm), .i_rx_done(c_rxd), .i_rx_data(c_dat),
    .i_rd_addr(c_addr), .o_rd_data(c_rd), .o_pc(c_pc), .o_state(c_st), .o_busy(c_busy),
    .o_done(c_done), .o_timeout(c_to), .o_word_count(c_wc));

  logic [31:0] wa [65];
  logic [31:0] wc_m [33];
  logic [7:0]  q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic a_send(input logic [7:0] b);
    a_rxd = 1'b1; a_dat = b; tick(1); a_rxd = 1'b0;
  endtask
  task automatic b_send(input logic [7:0] b);
    b_rxd = 1'b1; b_dat = b; tick(1); b_rxd = 1'b0;
  endtask
  task automatic c_send(input logic [7:0] b);
    c_rxd = 1'b1; c_dat = b; tick(1); c_rxd = 1'b0;
  endtask

  task automatic a_read(input int ad, input logic [31:0] exp);
    a_addr = 7'(ad); tick(1); chk($sformatf("a_rd[%0d]", ad), a_rd, exp);
  endtask

  // Full dump of wa[] into config A, low byte of each word first.
  task automatic a_dump(input bit gaps);
    a_arm = 1'b1; tick(1); a_arm = 1'b0;
    chk("a_state_pc", 32'(a_st), 1);
    for (int w = 0; w < 65; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (gaps) tick($urandom_range(0, 3));
        if (w == 64 && k == 3) chk("a_done_early", 32'(a_done), 0);
        a_send(8'((wa[w] >> (8 * k)) & 32'hFF));
      end
    end
    chk("a_done", 32'(a_done), 1);
    chk("a_state_done", 32'(a_st), 4);
    chk("a_busy_done", 32'(a_busy), 0);
    chk("a_wc_done", 32'(a_wc), 65);
    chk("a_pc", a_pc, wa[0]);
    tick(1);
    chk("a_done_pulse", 32'(a_done), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_arm = 0; a_rxd = 0; a_dat = 0; a_addr = 0;
    b_arm = 0; b_rxd = 0; b_dat = 0; b_addr = 0;
    c_arm = 0; c_rxd = 0; c_dat = 0; c_addr = 0;
    #2;
    chk("rst_state", 32'(a_st), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_to", 32'(a_to), 0);
    chk("rst_wc", 32'(a_wc), 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_rd", a_rd, 0);
    #10 rst_n = 1'b1;
    tick(1);

    // strobes before any arm are ignored
    a_send(8'h55);
    chk("a_idle_ignore", 32'(a_wc), 0);

    // directed dump: PC=0E, reg k=3k, mem k=A500000k
    wa[0] = 32'h0000000E;
    for (int k = 0; k < 32; k++) begin
      wa[1 + k]  = 32'(3 * k);
      wa[33 + k] = 32'hA5000000 + 32'(k);
    end
    a_dump(1'b0);
    chk("a_pc_0e", a_pc, 32'h0000000E);
    a_read(5, 32'h0000000C);
    a_read(35, 32'hA5000002);
    a_read(65, 32'h0);

    // random dumps with random inter-byte gaps, full image readback
    for (int r = 0; r < 2; r++) begin
      foreach (wa[i]) wa[i] = $urandom;
      a_dump(1'b1);
      for (int ad = 0; ad <= 66; ad++) a_read(ad, (ad < 65) ? wa[ad] : 32'h0);
      a_read(127, 32'h0);
    end

    // timeout: 10 bytes then silence
    a_arm = 1'b1; tick(1); a_arm = 1'b0;
    q.delete();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      q.push_back(b);
      a_send(b);
    end
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (i == 99) begin
        chk("a_to_early", 32'(a_to), 0);
        chk("a_busy_early", 32'(a_busy), 1);
      end
    end
    chk("a_to", 32'(a_to), 1);
    chk("a_to_state", 32'(a_st), 0);
    chk("a_to_wc", 32'(a_wc), 2);
    for (int i = 0; i < 8; i++) a_send(8'($urandom));
    chk("a_to_wc_hold", 32'(a_wc), 2);
    chk("a_to_state_hold", 32'(a_st), 0);
    a_read(0, 32'(q[0]) | (32'(q[1]) << 8) | (32'(q[2]) << 16) | (32'(q[3]) << 24));
    a_read(1, 32'(q[4]) | (32'(q[5]) << 8) | (32'(q[6]) << 16) | (32'(q[7]) << 24));

    // re-arm mid-word with a coincident strobe
    a_arm = 1'b1; tick(1); a_arm = 1'b0;
    chk("a_rearm_to_clr", 32'(a_to), 0);
    for (int i = 0; i < 6; i++) a_send(8'($urandom));
    a_arm = 1'b1; a_rxd = 1'b1; a_dat = 8'($urandom); tick(1); a_arm = 1'b0; a_rxd = 1'b0;
    chk("a_rearm_wc0", 32'(a_wc), 0);
    chk("a_rearm_state", 32'(a_st), 1);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      q.push_back(b);
      a_send(b);
    end
    chk("a_rearm_wc1", 32'(a_wc), 1);
    chk("a_rearm_pc", a_pc, 32'(q[0]) | (32'(q[1]) << 8) | (32'(q[2]) << 16) | (32'(q[3]) << 24));
    chk("a_rearm_to", 32'(a_to), 0);
    chk("a_rearm_regs", 32'(a_st), 2);

    // async reset while in MEM
    a_arm = 1'b1; tick(1); a_arm = 1'b0;
    for (int i = 0; i < 38 * 4; i++) a_send(8'($urandom_range(1, 255)));
    chk("a_mem_state", 32'(a_st), 3);
    chk("a_mem_wc", 32'(a_wc), 38);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(a_st), 0);
    chk("ar_busy", 32'(a_busy), 0);
    chk("ar_done", 32'(a_done), 0);
    chk("ar_to", 32'(a_to), 0);
    chk("ar_wc", 32'(a_wc), 0);
    chk("ar_pc", a_pc, 0);
    chk("ar_rd", a_rd, 0);
    #2 rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) a_send(8'($urandom));
    chk("ar_ignore_wc", 32'(a_wc), 0);
    chk("ar_ignore_st", 32'(a_st), 0);
    a_arm = 1'b1; tick(1); a_arm = 1'b0;
    for (int i = 0; i < 4; i++) a_send(8'($urandom));
    chk("ar_resume_wc", 32'(a_wc), 1);

    // config B: MSB-first 16-bit, directed then random
    b_arm = 1'b1; tick(1); b_arm = 1'b0;
    b_send(8'h12); b_send(8'h34); b_send(8'hAB);
    chk("b_done_early", 32'(b_done), 0);
    b_send(8'hCD);
    chk("b_done", 32'(b_done), 1);
    chk("b_state", 32'(b_st), 4);
    chk("b_pc", 32'(b_pc), 32'h1234);
    b_addr = 2'd1; tick(1); chk("b_rd1", 32'(b_rd), 32'hABCD);
    b_addr = 2'd2; tick(1); chk("b_rd2", 32'(b_rd), 0);
    for (int r = 0; r < 3; r++) begin
      logic [7:0] bb [4];
      foreach (bb[i]) bb[i] = 8'($urandom);
      b_arm = 1'b1; tick(1); b_arm = 1'b0;
      b_send(bb[0]);
      // timeout disabled: a long stall keeps the capture alive
      if (r == 0) begin
        tick(300);
        chk("b_no_to_busy", 32'(b_busy), 1);
        chk("b_no_to_flag", 32'(b_to), 0);
      end
      for (int i = 1; i < 4; i++) b_send(bb[i]);
      chk("b_rnd_done", 32'(b_done), 1);
      chk("b_rnd_pc", 32'(b_pc), 32'(bb[0]) * 256 + 32'(bb[1]));
      b_addr = 2'd0; tick(1); chk("b_rnd_rd0", 32'(b_rd), 32'(bb[0]) * 256 + 32'(bb[1]));
      b_addr = 2'd1; tick(1); chk("b_rnd_rd1", 32'(b_rd), 32'(bb[2]) * 256 + 32'(bb[3]));
    end

    // config C: registers only, 132 bytes then extras
    foreach (wc_m[i]) wc_m[i] = $urandom;
    c_arm = 1'b1; tick(1); c_arm = 1'b0;
    for (int w = 0; w < 33; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (w == 32 && k == 3) chk("c_done_early", 32'(c_done), 0);
        c_send(8'((wc_m[w] >> (8 * k)) & 32'hFF));
      end
    end
    chk("c_done", 32'(c_done), 1);
    chk("c_state", 32'(c_st), 4);
    for (int i = 0; i < 8; i++) c_send(8'($urandom));
    chk("c_wc", 32'(c_wc), 33);
    chk("c_state_hold", 32'(c_st), 4);
    chk("c_pc", c_pc, wc_m[0]);
    for (int i = 0; i < 6; i++) begin
      int ad;
      ad = (i == 5) ? 33 : ((i == 4) ? 32 : $urandom_range(0, 32));
      c_addr = 6'(ad); tick(1);
      chk($sformatf("c_rd[%0d]", ad), c_rd, (ad < 33) ? wc_m[ad] : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_dump_collector.md
# uart_dump_collector

Synthesizable receive-side collector for the MIPS debug dump stream, parametrised in word width, byte order, register count and memory depth. It sits behind the host-side UART receiver. It consumes byte strobes and assembles them into words. It files each word into a PC / register-file / data-memory image and exposes the result through a registered read port. It adds three things the fixed-format capture lacked: explicit arm/re-arm, an inter-byte timeout with resync, and a completion pulse.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, UART payload width
- NUM_REGS, 32, register words following the PC word
- MEM_WORDS, 32, memory words following the registers; 0 allowed
- MSB_FIRST, 0, 0 = first byte lands in bits [BYTE_WIDTH-1:0]; 1 = first byte lands in the top byte
- TIMEOUT_CYCLES, 200000, allowed idle cycles between bytes while busy; 0 disables the timeout
- Derived localparams: BPW = DATA_WIDTH/BYTE_WIDTH; TOTAL = 1+NUM_REGS+MEM_WORDS; AW = $clog2(TOTAL+1)
- i_clock  in  1  single clock
- i_reset  in  1  **asynchronous, active-low reset**
- i_arm  in  1  one-cycle pulse that starts or restarts a capture
- i_rx_done  in  1  one-cycle strobe marking i_rx_data as valid
- i_rx_data  in  BYTE_WIDTH  received byte
- i_rd_addr  in  AW  image address: 0 = PC; 1..NUM_REGS = registers; NUM_REGS+1..TOTAL-1 = memory
- o_rd_data  out  DATA_WIDTH  registered read data
- o_pc  out  DATA_WIDTH  last captured PC word
- o_state  out  3  current FSM state encoding
- o_busy  out  1  high in PC, REGS and MEM states
- o_done  out  1  one-cycle pulse when the image is complete
- o_timeout  out  1  sticky timeout flag; cleared by i_arm
- o_word_count  out  AW  number of words stored in the current capture

## Operation
- States and encodings: IDLE=0, PC=1, REGS=2, MEM=3, DONE=4.
- IDLE --i_arm--> PC.
- PC --1 word stored--> REGS, or MEM if NUM_REGS=0.
- REGS --NUM_REGS words stored--> MEM, or DONE if MEM_WORDS=0.
- MEM --MEM_WORDS words stored--> DONE.
- DONE --i_arm--> PC.
- In any state, i_arm clears the byte counter, o_word_count and o_timeout, then enters PC.
- i_rx_done is ignored in IDLE and DONE.
- When i_arm and i_rx_done arrive in the same cycle, the arm wins and the byte is discarded.
- Byte assembly:
  - Byte counter runs 0..BPW-1.
  - LSB-first: byte k is placed at [k*BYTE_WIDTH +: BYTE_WIDTH].
  - MSB-first: shift register, left shift by BYTE_WIDTH, new byte enters the low bits.
- On the BPW-th byte, the assembled word is written to image[o_word_count] and o_word_count increments.
- A word at address 0 is also loaded into o_pc.
- Timeout:
  - Idle counter is cleared on every accepted byte and on arm.
  - It counts each busy cycle with no strobe.
  - On reaching TIMEOUT_CYCLES: o_timeout=1, state goes to IDLE, any partial word is dropped.
  - Stored words remain readable.
- Read port: o_rd_data = image[i_rd_addr], registered. Addresses >= TOTAL return 0.

## Timing
- Reset values: state IDLE; o_rd_data, o_pc, o_word_count = 0; o_busy, o_done, o_timeout = 0.
- The image array is not reset. Its contents are valid only up to o_word_count.
- Word write and counter increment take effect on the edge that samples the last byte strobe.
- o_done is high for exactly one cycle, the cycle after that edge, coincident with o_state=DONE.
- o_busy drops in the same cycle o_done rises.
- Read latency is 1 cycle. A read of the word being written in the same cycle returns the old value.
- Strobes can arrive back-to-back every cycle; there is no throughput limit.
- Asserting i_reset mid-capture takes effect immediately. Capture resumes only after a new i_arm.

## Structure
- Shared package `dump_pkg`:
  - state encoding constants
  - section base addresses: PC_ADDR=0, REG_BASE=1, MEM_BASE=1+NUM_REGS
- One sub-module, `byte_word_packer`, covering the BPW counter, MSB_FIRST assembly and the word-valid strobe.
- FSM, timeout counter and image RAM stay in the top of the block.

## Test plan
- Full LSB-first dump (32/8/32/32):
  - Stimulus: arm, then bytes 0E 00 00 00; registers k=3k; memory k=A500000k.
  - Response: o_done after byte 260; o_pc=0x0000000E; rd 5 -> 0x0C; rd 35 -> 0xA5000002; rd 65 -> 0.
- MSB_FIRST=1, DATA_WIDTH=16, NUM_REGS=1, MEM_WORDS=0:
  - Stimulus: arm, bytes 12 34 AB CD.
  - Response: o_pc=0x1234; rd 1 -> 0xABCD; o_done at byte 4.
- TIMEOUT_CYCLES=100:
  - Stimulus: arm, 10 bytes, then silence.
  - Response: o_timeout=1 exactly 100 cycles after the last strobe; state IDLE; o_word_count=2; later strobes ignored.
- Re-arm:
  - Stimulus: arm plus strobe in the same cycle after 6 bytes, then 4 more bytes.
  - Response: o_word_count=1; o_pc = the new 4 bytes; o_timeout=0.
- Async reset mid-MEM:
  - Stimulus: i_reset low between edges.
  - Response: all outputs 0 immediately, state IDLE; strobes ignored until the next arm.
- MEM_WORDS=0, NUM_REGS=32:
  - Stimulus: arm, then 132 bytes.
  - Response: o_done at byte 132; extra bytes ignored; o_word_count stays at 33.
